// File: rtl/coord_x_gen.sv
// coord_x_gen: raster-order coordinate generator for the interpolation datapath.
// Walks a COLS x ROWS block, emitting signed (X, Y) positions over a
// valid/ready link. WRITE_X strobes every transfer; WRITE_Y strobes the first
// transfer of each row. A start/done handshake frames each block.
module coord_x_gen #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 6
) (
  input  logic              CLK,
  input  logic              RST_ASYNC_N,
  input  logic              START,
  input  logic [DATA_W-1:0] X0,
  input  logic [DATA_W-1:0] Y0,
  input  logic [DATA_W-1:0] STEP_X,
  input  logic [DATA_W-1:0] STEP_Y,
  input  logic [CNT_W-1:0]  COLS,
  input  logic [CNT_W-1:0]  ROWS,
  input  logic              READY,
  output logic              VALID,
  output logic [DATA_W-1:0] X_OUT,
  output logic [DATA_W-1:0] Y_OUT,
  output logic              WRITE_X,
  output logic              WRITE_Y,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Configuration captured on an accepted START; held for the whole block.
  logic signed [DATA_W-1:0] x0_lat, x0_lat_nxt;
  logic signed [DATA_W-1:0] step_x_lat, step_x_lat_nxt;
  logic signed [DATA_W-1:0] step_y_lat, step_y_lat_nxt;
  logic [CNT_W-1:0]         cols_lat, cols_lat_nxt;
  logic [CNT_W-1:0]         rows_lat, rows_lat_nxt;

  // Walking state: coordinate accumulators and raster position.
  logic signed [DATA_W-1:0] x_acc, x_acc_nxt;
  logic signed [DATA_W-1:0] y_acc, y_acc_nxt;
  logic [CNT_W-1:0]         col_cnt, col_cnt_nxt;
  logic [CNT_W-1:0]         row_cnt, row_cnt_nxt;

  logic start_ok;
  logic last_col;
  logic last_row;

  // Two's complement add that simply drops the carry: coordinates wrap.
  function automatic logic signed [DATA_W-1:0] wrap_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] sum;
    sum = a + b;
    return sum;
  endfunction

  // Block-shape decode: a degenerate block skips RUN entirely.
  always_comb begin
    start_ok = START && (COLS != '0) && (ROWS != '0);
    last_col = (col_cnt == (cols_lat - CNT_W'(1)));
    last_row = (row_cnt == (rows_lat - CNT_W'(1)));
  end

  // Next-state and walking logic; a transfer is RUN with READY high.
  always_comb begin
    state_nxt      = state;
    x0_lat_nxt     = x0_lat;
    step_x_lat_nxt = step_x_lat;
    step_y_lat_nxt = step_y_lat;
    cols_lat_nxt   = cols_lat;
    rows_lat_nxt   = rows_lat;
    x_acc_nxt      = x_acc;
    y_acc_nxt      = y_acc;
    col_cnt_nxt    = col_cnt;
    row_cnt_nxt    = row_cnt;

    unique case (state)
      S_IDLE: begin
        if (START) begin
          if (start_ok) begin
            x0_lat_nxt     = $signed(X0);
            step_x_lat_nxt = $signed(STEP_X);
            step_y_lat_nxt = $signed(STEP_Y);
            cols_lat_nxt   = COLS;
            rows_lat_nxt   = ROWS;
            x_acc_nxt      = $signed(X0);
            y_acc_nxt      = $signed(Y0);
            col_cnt_nxt    = '0;
            row_cnt_nxt    = '0;
            state_nxt      = S_RUN;
          end else begin
            state_nxt = S_FINISH;
          end
        end
      end

      S_RUN: begin
        // START and configuration inputs are deliberately not looked at here.
        if (READY) begin
          if (last_col) begin
            col_cnt_nxt = '0;
            x_acc_nxt   = x0_lat;
            if (last_row) begin
              state_nxt = S_FINISH;
            end else begin
              row_cnt_nxt = row_cnt + CNT_W'(1);
              y_acc_nxt   = wrap_add(y_acc, step_y_lat);
            end
          end else begin
            col_cnt_nxt = col_cnt + CNT_W'(1);
            x_acc_nxt   = wrap_add(x_acc, step_x_lat);
          end
        end
      end

      S_FINISH: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, configuration and walking registers; reset aborts any block.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state      <= S_IDLE;
      x0_lat     <= '0;
      step_x_lat <= '0;
      step_y_lat <= '0;
      cols_lat   <= '0;
      rows_lat   <= '0;
      x_acc      <= '0;
      y_acc      <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      x0_lat     <= x0_lat_nxt;
      step_x_lat <= step_x_lat_nxt;
      step_y_lat <= step_y_lat_nxt;
      cols_lat   <= cols_lat_nxt;
      rows_lat   <= rows_lat_nxt;
      x_acc      <= x_acc_nxt;
      y_acc      <= y_acc_nxt;
      col_cnt    <= col_cnt_nxt;
      row_cnt    <= row_cnt_nxt;
    end
  end

  // Outputs decode straight from registers, so reset clears them at once.
  always_comb begin
    VALID   = (state == S_RUN);
    BUSY    = (state == S_RUN);
    DONE    = (state == S_FINISH);
    X_OUT   = x_acc;
    Y_OUT   = y_acc;
    WRITE_X = VALID && READY;
    WRITE_Y = VALID && READY && (col_cnt == '0);
  end

endmodule
